// File: rtl/seq_signed_divider_if.sv
// Request/result bundle for the sequential signed divider.
// The master drives start and the operands; the slave returns the registered result.
interface seq_signed_divider_if #(
  parameter int N = 8
) ();
  logic             start;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic [N-1:0]     quotient;
  logic [N-1:0]     remainder;
  logic             err;
  logic             done;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, err, done
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, err, done
  );
endinterface

// File: rtl/seq_signed_divider.sv
// Restoring 2N/N signed divider: one quotient bit per clock on operand magnitudes,
// followed by a sign-fix step that also detects quotient overflow.
module seq_signed_divider #(
  parameter int N = 8
) (
  input logic                 clk,
  input logic                 reset,
  seq_signed_divider_if.slave bus
);

  localparam int CW = $clog2(2 * N) + 1;
  // Largest positive and largest negative quotient magnitudes that fit in N signed bits.
  localparam logic [2*N-1:0] QPOS_MAX = {{(N + 1){1'b0}}, {(N - 1){1'b1}}};
  localparam logic [2*N-1:0] QNEG_MAX = QPOS_MAX + 1'b1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t          state_reg, state_next;
  logic [2*N-1:0]  shreg_reg, shreg_next;
  logic [N-1:0]    part_reg,  part_next;
  logic [N-1:0]    dvs_reg,   dvs_next;
  logic            sd_reg,    sd_next;
  logic            sv_reg,    sv_next;
  logic [CW-1:0]   cnt_reg,   cnt_next;
  logic [N-1:0]    quo_reg,   quo_next;
  logic [N-1:0]    rem_reg,   rem_next;
  logic            err_reg,   err_next;
  logic            done_reg,  done_next;

  logic [N:0]      trial;
  logic [N-1:0]    diff;
  logic [2*N-1:0]  dvd_abs;
  logic [N-1:0]    dvs_abs;
  logic            neg_q;
  logic            ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      part_reg  <= '0;
      dvs_reg   <= '0;
      sd_reg    <= 1'b0;
      sv_reg    <= 1'b0;
      cnt_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      err_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      part_reg  <= part_next;
      dvs_reg   <= dvs_next;
      sd_reg    <= sd_next;
      sv_reg    <= sv_next;
      cnt_reg   <= cnt_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      err_reg   <= err_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    part_next  = part_reg;
    dvs_next   = dvs_reg;
    sd_next    = sd_reg;
    sv_next    = sv_reg;
    cnt_next   = cnt_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    err_next   = err_reg;
    done_next  = done_reg;

    trial   = {part_reg, shreg_reg[2*N-1]};
    // The restored remainder is always below the divisor, so N-bit modular subtraction suffices.
    diff    = trial[N-1:0] - dvs_reg;
    // Read as unsigned, the negated most-negative dividend is exactly 2^(2N-1): no wrap.
    dvd_abs = bus.dividend[2*N-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    dvs_abs = bus.divisor[N-1] ? (~bus.divisor + 1'b1) : bus.divisor;
    neg_q   = (sd_reg ^ sv_reg) && (shreg_reg != '0);
    ovf     = neg_q ? (shreg_reg > QNEG_MAX) : (shreg_reg > QPOS_MAX);

    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          done_next = 1'b0;
          if (bus.divisor == '0) begin
            quo_next   = '0;
            rem_next   = '0;
            err_next   = 1'b1;
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            shreg_next = dvd_abs;
            dvs_next   = dvs_abs;
            sd_next    = bus.dividend[2*N-1];
            sv_next    = bus.divisor[N-1];
            part_next  = '0;
            cnt_next   = '0;
            state_next = ITER;
          end
        end
      end
      ITER: begin
        // Quotient bits shift into the LSB end as dividend bits leave the MSB end.
        if (trial >= {1'b0, dvs_reg}) begin
          part_next  = diff;
          shreg_next = {shreg_reg[2*N-2:0], 1'b1};
        end else begin
          part_next  = trial[N-1:0];
          shreg_next = {shreg_reg[2*N-2:0], 1'b0};
        end
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CW'(2 * N - 1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        quo_next   = ovf ? '0 : (neg_q ? -shreg_reg[N-1:0] : shreg_reg[N-1:0]);
        rem_next   = ovf ? '0 : (sd_reg ? -part_reg : part_reg);
        err_next   = ovf;
        done_next  = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.quotient  = quo_reg;
  assign bus.remainder = rem_reg;
  assign bus.err       = err_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider: the driver queues reference results,
// an independent monitor checks each result the DUT presents, including its timing.
module tb_seq_signed_divider;
  localparam int N = 8;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         e;
    int           due;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_results = 0;
  logic done_prev = 1'b0;
  logic start_smp = 1'b0;
  exp_t sb[$];

  seq_signed_divider_if #(.N(N)) bus ();

  seq_signed_divider #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    start_smp <= bus.start;
  end

  // Reference: truncating integer division, remainder takes dividend sign, N-bit range check.
  function automatic exp_t model(input logic signed [2*N-1:0] a,
                                 input logic signed [N-1:0] b, input int due);
    exp_t   x;
    longint qa;
    longint ra;
    x.due = due;
    x.q   = '0;
    x.r   = '0;
    x.e   = 1'b1;
    if (b != 0) begin
      qa = longint'(a) / longint'(b);
      ra = longint'(a) % longint'(b);
      if (qa >= -(longint'(1) << (N - 1)) && qa <= (longint'(1) << (N - 1)) - 1) begin
        x.q = qa[N-1:0];
        x.r = ra[N-1:0];
        x.e = 1'b0;
      end
    end
    return x;
  endfunction

  // Monitor: a new result is done rising, or done staying high after a start was sampled.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (bus.done && (!done_prev || start_smp)) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_result: got q=%0d r=%0d err=%0b at edge %0d, required no result",
                   $signed(bus.quotient), $signed(bus.remainder), bus.err, cyc);
        end else begin
          x = sb.pop_front();
          if (bus.quotient !== x.q || bus.remainder !== x.r || bus.err !== x.e || cyc != x.due) begin
            n_bad++;
            $display("FAIL result: got q=%0d r=%0d err=%0b edge=%0d, required q=%0d r=%0d err=%0b edge=%0d",
                     $signed(bus.quotient), $signed(bus.remainder), bus.err, cyc,
                     $signed(x.q), $signed(x.r), x.e, x.due);
          end else begin
            $display("ok q=%0d r=%0d err=%0b edge=%0d",
                     $signed(bus.quotient), $signed(bus.remainder), bus.err, cyc);
          end
        end
        n_results++;
      end
      done_prev = bus.done;
    end
  end

  task automatic wait_result(input int target);
    int k;
    k = 0;
    while (n_results < target && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (n_results < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got %0d results, required %0d", n_results, target);
    end
  endtask

  // Called at a negedge; the following posedge samples start.
  task automatic do_op(input logic [2*N-1:0] a, input logic [N-1:0] b);
    int target;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    sb.push_back(model(a, b, cyc + 1 + ((b == '0) ? 0 : 2 * N + 1)));
    target = n_results + 1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_result(target);
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (bus.quotient !== '0 || bus.remainder !== '0 || bus.err !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got q=%h r=%h err=%b done=%b, required all 0",
               name, bus.quotient, bus.remainder, bus.err, bus.done);
    end else begin
      $display("ok %s: outputs cleared", name);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    int             m;
    int             e;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;

    do_op(16'd100, 8'd7);
    do_op(16'hFF9C, 8'd7);
    do_op(16'd100, 8'hF9);
    do_op(16'hFF80, 8'd1);
    do_op(16'h8000, 8'hFF);
    do_op(16'h1234, 8'h00);
    do_op(16'h1234, 8'h00);
    do_op(16'h8000, 8'h80);
    do_op(16'h4000, 8'h80);
    do_op(16'h3F80, 8'h80);
    do_op(16'h0000, 8'h05);

    // Start during ITER with other operands must be ignored.
    bus.dividend = 16'd100;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    sb.push_back(model(16'd100, 8'd7, cyc + 1 + 2 * N + 1));
    e = n_results + 1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.dividend = 16'hFF00;
    bus.divisor  = 8'd3;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_result(e);

    // Asynchronous reset mid-operation; the aborted result must never appear.
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd3;
    bus.start    = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < e + 8) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_op(16'd100, 8'd7);

    for (int i = 0; i < 2000; i++) begin
      a = (2 * N)'($urandom);
      b = N'($urandom);
      m = $urandom_range(0, 9);
      if (m < 5) a = (2 * N)'($signed(a) >>> $urandom_range(4, 12));
      if (m == 5) b = '0;
      if (m == 6) b = '1;
      if (m == 7) b = 8'h80;
      if (m == 8) a = 16'h8000;
      do_op(a, b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d pending results, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
